instr_fetch: RTL

Front end of the CPU that sits between program ROM and instr_dec. It drives the fetch address from its own PC and reads the opcode word. From the opcode's addressing-mode fields it works out the instruction length (1-3 words) and collects the source and destination extension words. It then presents one complete instruction to the decoder through a valid/ready handshake, and it accepts PC redirects from jump and branch logic.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles 1-3 word instructions from ROM and hands them to the decoder.
// Valid one cycle after the last word is captured; holds in S_HOLD with fetch stopped until instr_ready.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'hC000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MDB_out,
  output logic [15:0] MAB_fetch,
  output logic        fetch_req,
  input  logic        PC_load,
  input  logic [15:0] PC_new,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] IR,
  output logic [15:0] EXT_SRC,
  output logic [15:0] EXT_DST,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic [15:0] PC_out,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_SRC  = 2'd1,
    S_DST  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_ext_src;
  logic [15:0] r_ext_dst;
  logic [15:0] r_instr_pc;
  logic [1:0]  r_len;
  logic        r_need_dst;

  logic        w_fmt1;
  logic        w_fmt2;
  logic [3:0]  w_rs;
  logic [1:0]  w_as;
  logic        w_need_src;
  logic        w_need_dst;
  logic [1:0]  w_len;
  logic [15:0] w_pc_inc;

  // Jumps (001x) fall outside both formats and therefore decode as one word.
  assign w_fmt1     = (MDB_out[15:12] >= 4'h4);
  assign w_fmt2     = (MDB_out[15:10] == 6'b000100);
  assign w_rs       = w_fmt1 ? MDB_out[11:8] : MDB_out[3:0];
  assign w_as       = MDB_out[5:4];
  assign w_need_src = (w_fmt1 || w_fmt2) && (MDB_out != 16'h1300) &&
                      (((w_as == 2'b01) && (w_rs != 4'd3)) ||
                       ((w_as == 2'b11) && (w_rs == 4'd0)));
  assign w_need_dst = w_fmt1 && MDB_out[7];
  assign w_len      = 2'd1 + {1'b0, w_need_src} + {1'b0, w_need_dst};
  assign w_pc_inc   = r_pc + 16'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_OP;
      r_pc       <= RESET_PC & 16'hFFFE;
      r_ir       <= 16'h0000;
      r_ext_src  <= 16'h0000;
      r_ext_dst  <= 16'h0000;
      r_instr_pc <= 16'h0000;
      r_len      <= 2'd0;
      r_need_dst <= 1'b0;
    end else if (PC_load) begin
      // Redirect beats any capture or consume happening on the same edge.
      r_pc    <= PC_new & 16'hFFFE;
      r_state <= S_OP;
    end else begin
      case (r_state)
        S_OP: begin
          r_ir       <= MDB_out;
          r_instr_pc <= r_pc;
          r_pc       <= w_pc_inc;
          r_ext_src  <= 16'h0000;
          r_ext_dst  <= 16'h0000;
          r_len      <= w_len;
          r_need_dst <= w_need_dst;
          r_state    <= w_need_src ? S_SRC : (w_need_dst ? S_DST : S_HOLD);
        end
        S_SRC: begin
          r_ext_src <= MDB_out;
          r_pc      <= w_pc_inc;
          r_state   <= r_need_dst ? S_DST : S_HOLD;
        end
        S_DST: begin
          r_ext_dst <= MDB_out;
          r_pc      <= w_pc_inc;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) r_state <= S_OP;
        end
        default: r_state <= S_OP;
      endcase
    end
  end

  assign MAB_fetch   = r_pc;
  assign PC_out      = r_pc;
  assign fetch_req   = (r_state != S_HOLD);
  assign instr_valid = (r_state == S_HOLD);
  assign illegal     = instr_valid && (r_ir[15:12] == 4'b0000);
  assign IR          = r_ir;
  assign EXT_SRC     = r_ext_src;
  assign EXT_DST     = r_ext_dst;
  assign instr_len   = r_len;
  assign instr_pc    = r_instr_pc;

endmodule
